// File: rtl/uart_line_assembler.sv
// uart_line_assembler: edits received chars into a line buffer with optional echo, then streams each finished line
module uart_line_assembler #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] EOL_CHAR = 8'h0D,
  parameter logic [DATA_WIDTH-1:0] BS_CHAR = 8'h08,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic                  echo_en,
  output logic [DATA_WIDTH-1:0] line_data,
  output logic                  line_valid,
  input  logic                  line_ready,
  output logic                  line_last,
  output logic [LW-1:0]         line_len,
  output logic                  line_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  typedef enum logic [2:0] {COLLECT, ECHO, ERASE1, ERASE2, ERASE3, EMIT} state_t;
  state_t state, state_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] hold;
  logic [LW-1:0] count, rd_ptr;
  logic ovf, to_emit;
  logic rx_hs, tx_hs, line_hs, is_eol, is_bs, empty, full, last, store;
  assign is_eol = rx_data == EOL_CHAR;
  assign is_bs = rx_data == BS_CHAR;
  assign empty = count == '0;
  assign full = count == FULL;
  assign last = rd_ptr == count - LW'(1);
  assign rx_hs = rx_valid && rx_ready;
  assign tx_hs = tx_valid && tx_ready;
  assign line_hs = line_valid && line_ready;
  assign store = rx_hs && !is_eol && !is_bs && !full;
  // All outputs are forced low while rst is held, regardless of state
  assign rx_ready = !rst && state == COLLECT;
  assign tx_valid = !rst && (state == ECHO || state == ERASE1 || state == ERASE2 || state == ERASE3);
  assign tx_data = !tx_valid ? '0 : state == ECHO ? hold : state == ERASE2 ? DATA_WIDTH'(8'h20) : BS_CHAR;
  assign line_valid = !rst && state == EMIT;
  assign line_data = line_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign line_len = line_valid ? count : '0;
  assign line_last = line_valid && last;
  assign line_ovf = line_valid && ovf;
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (rx_hs) state_nxt = is_eol ? (echo_en ? ECHO : (empty ? COLLECT : EMIT))
                                   : is_bs ? (echo_en && !empty ? ERASE1 : COLLECT)
                                   : (echo_en && !full ? ECHO : COLLECT);
      ECHO:    if (tx_hs) state_nxt = to_emit ? EMIT : COLLECT;
      ERASE1:  if (tx_hs) state_nxt = ERASE2;
      ERASE2:  if (tx_hs) state_nxt = ERASE3;
      ERASE3:  if (tx_hs) state_nxt = COLLECT;
      EMIT:    if (line_hs && last) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
      count <= '0;
      rd_ptr <= '0;
      ovf <= 1'b0;
      hold <= '0;
      to_emit <= 1'b0;
    end else begin
      state <= state_nxt;
      if (rx_hs) begin
        hold <= rx_data;
        to_emit <= is_eol && !empty;
        if (is_bs && !empty) count <= count - LW'(1);
        else if (!is_eol && !is_bs) begin
          if (full) ovf <= 1'b1;
          else count <= count + LW'(1);
        end
      end
      if (line_hs) begin
        rd_ptr <= last ? '0 : rd_ptr + LW'(1);
        if (last) begin
          count <= '0;
          ovf <= 1'b0;
        end
      end
    end
  end
  always_ff @(posedge clk) if (store) mem[count[AW-1:0]] <= rx_data;
endmodule

// File: tb/tb_uart_line_assembler.sv
// tb_uart_line_assembler: queue-based line/echo model checked every cycle, plus literal per-test expectations
module tb_uart_line_assembler;
  localparam int D = 4;
  typedef struct packed {logic [7:0] d; logic l; logic [2:0] n; logic o;} beat_t;
  logic clk = 0, rst = 1;
  logic [7:0] rx_data = 0;
  logic rx_valid = 0, tx_ready = 1, echo_en = 0, line_ready = 1;
  logic rx_ready, tx_valid, line_valid, line_last, line_ovf;
  logic [7:0] tx_data, line_data;
  logic [2:0] line_len;
  int n_chk = 0, n_fail = 0;
  logic [7:0] mbuf[$], txq[$], tx_log[$];
  logic movf = 0;
  beat_t lq[$], line_log[$];

  uart_line_assembler #(.DATA_WIDTH(8), .DEPTH(D), .EOL_CHAR(8'h0D), .BS_CHAR(8'h08)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .echo_en(echo_en),
    .line_data(line_data), .line_valid(line_valid), .line_ready(line_ready),
    .line_last(line_last), .line_len(line_len), .line_ovf(line_ovf));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_rx(input logic [7:0] c, input logic e);
    beat_t b;
    if (c == 8'h0D) begin
      if (e) txq.push_back(c);
      for (int i = 0; i < mbuf.size(); i++) begin
        b.d = mbuf[i];
        b.l = i == mbuf.size() - 1;
        b.n = 3'(mbuf.size());
        b.o = movf;
        lq.push_back(b);
      end
      if (mbuf.size() > 0) begin
        mbuf.delete();
        movf = 0;
      end
    end else if (c == 8'h08) begin
      if (mbuf.size() > 0) begin
        void'(mbuf.pop_back());
        if (e) begin
          txq.push_back(8'h08);
          txq.push_back(8'h20);
          txq.push_back(8'h08);
        end
      end
    end else if (mbuf.size() < D) begin
      mbuf.push_back(c);
      if (e) txq.push_back(c);
    end else movf = 1;
  endtask

  task automatic monitor();
    beat_t b;
    if (rst) begin
      chk("rst_rx_ready", rx_ready, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_line_valid", line_valid, 0);
      mbuf.delete();
      txq.delete();
      lq.delete();
      movf = 0;
    end else begin
      chk("rx_ready", rx_ready, txq.size() == 0 && lq.size() == 0);
      chk("tx_valid", tx_valid, txq.size() != 0);
      chk("line_valid", line_valid, txq.size() == 0 && lq.size() != 0);
      if (tx_valid && txq.size() > 0) chk("tx_data", tx_data, txq[0]);
      if (line_valid && lq.size() > 0) begin
        chk("line_data", line_data, lq[0].d);
        chk("line_last", line_last, lq[0].l);
        chk("line_len", line_len, lq[0].n);
        chk("line_ovf", line_ovf, lq[0].o);
      end
      if (tx_valid && tx_ready) begin
        tx_log.push_back(tx_data);
        if (txq.size() > 0) void'(txq.pop_front());
      end
      if (line_valid && line_ready) begin
        b.d = line_data;
        b.l = line_last;
        b.n = line_len;
        b.o = line_ovf;
        line_log.push_back(b);
        if (lq.size() > 0) void'(lq.pop_front());
      end
      if (rx_valid && rx_ready) model_rx(rx_data, echo_en);
    end
  endtask

  task automatic wait_rx();
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rx_ready) break;
    end
    chk("rx_hs_wait", k < 100, 1);
    @(posedge clk);
    #1;
    rx_valid = 0;
  endtask

  task automatic send(input logic [7:0] c);
    rx_data = c;
    rx_valid = 1;
    wait_rx();
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (txq.size() == 0 && lq.size() == 0) break;
    end
    chk("idle_wait", k < 200, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    tx_log.delete();
    line_log.delete();
  endtask

  task automatic check_tx(input string nm, input int n, input logic [63:0] exp);
    chk({nm, "_count"}, tx_log.size(), n);
    for (int i = 0; i < n && i < tx_log.size(); i++) chk({nm, "_char"}, tx_log[i], exp[8*(n-1-i) +: 8]);
  endtask

  task automatic check_line(input string nm, input int n, input logic [63:0] exp, input int len, input logic o);
    chk({nm, "_count"}, line_log.size(), n);
    for (int i = 0; i < n && i < line_log.size(); i++) begin
      chk({nm, "_data"}, line_log[i].d, exp[8*(n-1-i) +: 8]);
      chk({nm, "_last"}, line_log[i].l, i == n - 1);
      chk({nm, "_len"}, line_log[i].n, len);
      chk({nm, "_ovf"}, line_log[i].o, o);
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        monitor();
      end
    join_none
    @(negedge clk);
    chk("reset_rx_ready", rx_ready, 0);
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("post_reset_rx_ready", rx_ready, 1);
    @(posedge clk);
    #1;
    // 1: plain line with echo
    echo_en = 1;
    clear_logs();
    send(8'h61); send(8'h62); send(8'h0D);
    wait_idle();
    check_tx("t1_tx", 3, 64'h61_62_0D);
    check_line("t1_line", 2, 64'h61_62, 2, 0);
    // 2: backspace editing with echo
    clear_logs();
    send(8'h61); send(8'h62); send(8'h63); send(8'h08); send(8'h0D);
    wait_idle();
    check_tx("t2_tx", 7, 64'h61_62_63_08_20_08_0D);
    check_line("t2_line", 2, 64'h61_62, 2, 0);
    // 3: BS and EOL on empty buffer
    echo_en = 0;
    clear_logs();
    send(8'h08); send(8'h0D);
    wait_idle();
    @(negedge clk);
    chk("t3_rx_ready", rx_ready, 1);
    @(posedge clk);
    #1;
    check_tx("t3_tx", 0, 0);
    check_line("t3_line", 0, 0, 0, 0);
    // 4: overflow then a clean line
    echo_en = 1;
    clear_logs();
    for (int i = 0; i < 6; i++) send(8'h61 + 8'(i));
    send(8'h0D);
    wait_idle();
    check_tx("t4_tx", 5, 64'h61_62_63_64_0D);
    check_line("t4_line", 4, 64'h61_62_63_64, 4, 1);
    echo_en = 0;
    clear_logs();
    send(8'h67); send(8'h0D);
    wait_idle();
    check_line("t4_next", 1, 64'h67, 1, 0);
    // 5: back-pressure on tx and line
    echo_en = 1;
    tx_ready = 0;
    line_ready = 0;
    clear_logs();
    send(8'h6D);
    rx_data = 8'h6E;
    rx_valid = 1;
    repeat (10) begin
      @(negedge clk);
      chk("t5_rx_blocked", rx_ready, 0);
      chk("t5_tx_hold", tx_data, 8'h6D);
    end
    @(posedge clk);
    #1;
    tx_ready = 1;
    wait_rx();
    send(8'h0D);
    begin
      int k;
      for (k = 0; k < 50; k++) begin
        @(negedge clk);
        if (line_valid) break;
      end
      chk("t5_emit_wait", k < 50, 1);
    end
    repeat (5) begin
      @(negedge clk);
      chk("t5_line_hold", line_data, 8'h6D);
      chk("t5_rx_blocked_emit", rx_ready, 0);
    end
    @(posedge clk);
    #1;
    line_ready = 1;
    wait_idle();
    check_tx("t5_tx", 3, 64'h6D_6E_0D);
    check_line("t5_line", 2, 64'h6D_6E, 2, 0);
    // 6: reset in the middle of an emit
    echo_en = 0;
    line_ready = 0;
    clear_logs();
    send(8'h78); send(8'h79); send(8'h7A); send(8'h0D);
    @(negedge clk);
    chk("t6_in_emit", line_valid, 1);
    @(posedge clk);
    #1;
    rst = 1;
    @(negedge clk);
    chk("t6_rst_line_valid", line_valid, 0);
    @(posedge clk);
    #1;
    rst = 0;
    line_ready = 1;
    @(negedge clk);
    chk("t6_after_line_valid", line_valid, 0);
    chk("t6_after_rx_ready", rx_ready, 1);
    @(posedge clk);
    #1;
    check_line("t6_discard", 0, 0, 0, 0);
    send(8'h71); send(8'h0D);
    wait_idle();
    check_line("t6_fresh", 1, 64'h71, 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
